// File: rtl/compmul_arb_pkg.sv
// Shared types, widths and product-slice helpers for the compmul_arb block.
// The default operand format is Q4.12 in 16-bit signed components.
package compmul_arb_pkg;

  localparam int CM_DATA_WIDTH = 16;
  localparam int CM_FRAC_WIDTH = 12;
  localparam int CM_INT_WIDTH  = 4;

  // Full-precision product width: two products summed, plus headroom.
  localparam int CM_PROD_W  = 2 * CM_DATA_WIDTH + 2;

  // Result slice: drop FRAC_WIDTH LSBs (floor), keep DATA_WIDTH bits (wrap).
  function automatic int prod_hi(input int int_w, input int frac_w);
    return int_w + 2 * frac_w - 1;
  endfunction

  localparam int CM_PROD_HI = prod_hi(CM_INT_WIDTH, CM_FRAC_WIDTH);
  localparam int CM_PROD_LO = CM_FRAC_WIDTH;

  typedef struct packed {
    logic signed [CM_DATA_WIDTH-1:0] re;
    logic signed [CM_DATA_WIDTH-1:0] im;
  } cplx_t;

  // Requester id width, never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/compmul.sv
// Three-multiplier complex multiplier, purely combinational, full precision.
//   k1 = b_re*(a_re+a_im), k2 = a_re*(b_im-b_re), k3 = a_im*(b_re+b_im)
//   re = k1 - k3, im = k1 + k2
module compmul #(
  parameter int DW = 16
) (
  input  logic signed [DW-1:0]     i_a_re,
  input  logic signed [DW-1:0]     i_a_im,
  input  logic signed [DW-1:0]     i_b_re,
  input  logic signed [DW-1:0]     i_b_im,
  output logic signed [2*DW+1:0]   o_p_re,
  output logic signed [2*DW+1:0]   o_p_im
);

  localparam int PW = 2 * DW + 2;

  logic signed [PW-1:0] w_are, w_aim, w_bre, w_bim;
  logic signed [PW-1:0] w_k1, w_k2, w_k3;

  assign w_are = PW'(i_a_re);
  assign w_aim = PW'(i_a_im);
  assign w_bre = PW'(i_b_re);
  assign w_bim = PW'(i_b_im);

  // Shared partial products; all sums fit in PW bits without overflow.
  always_comb begin
    w_k1   = w_bre * (w_are + w_aim);
    w_k2   = w_are * (w_bim - w_bre);
    w_k3   = w_aim * (w_bre + w_bim);
    o_p_re = w_k1 - w_k3;
    o_p_im = w_k1 + w_k2;
  end

endmodule

// File: rtl/rr_grant.sv
// Combinational round-robin picker: searches req starting at ptr and
// returns a one-hot grant plus its encoded index. ptr must be < N.
module rr_grant #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [N-1:0]    o_grant,
  output logic [ID_W-1:0] o_id
);

  int   w_idx;
  logic w_found;

  // First requester at or after ptr (wrapping) wins.
  always_comb begin
    o_grant = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < N; i++) begin
      w_idx = (int'(i_ptr) + i) % N;
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_id           = ID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/compmul_arb.sv
// Round-robin arbiter feeding one shared two-stage complex multiplier.
// Optional build macro COMPMUL_ARB_PRIO0_EN: requester 0 gets strict
// priority and round-robin runs only over requesters 1..N_REQ-1.
module compmul_arb
  import compmul_arb_pkg::*;
#(
  parameter int DATA_WIDTH = CM_DATA_WIDTH,
  parameter int FRAC_WIDTH = CM_FRAC_WIDTH,
  parameter int INT_WIDTH  = CM_INT_WIDTH,
  parameter int N_REQ      = 4,
  parameter int ID_W       = id_w(N_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_clr,
  input  logic [N_REQ-1:0]              i_req_valid,
  output logic [N_REQ-1:0]              o_req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0]   i_a_re,
  input  logic [N_REQ*DATA_WIDTH-1:0]   i_a_im,
  input  logic [N_REQ*DATA_WIDTH-1:0]   i_b_re,
  input  logic [N_REQ*DATA_WIDTH-1:0]   i_b_im,
  output logic                          o_res_valid,
  input  logic                          i_res_ready,
  output logic [ID_W-1:0]               o_res_id,
  output logic [DATA_WIDTH-1:0]         o_res_re,
  output logic [DATA_WIDTH-1:0]         o_res_im
);

  localparam int PW = 2 * DATA_WIDTH + 2;
  localparam int HI = prod_hi(INT_WIDTH, FRAC_WIDTH);
  localparam int LO = FRAC_WIDTH;

  logic                  w_en;
  logic [N_REQ-1:0]      w_grant;
  logic [ID_W-1:0]       w_grant_id;
  logic                  w_accept;
  logic [ID_W-1:0]       r_ptr;

  logic                  r_s1_valid;
  logic [ID_W-1:0]       r_s1_id;
  logic [DATA_WIDTH-1:0] r_s1_are, r_s1_aim, r_s1_bre, r_s1_bim;

  logic                  r_res_valid;
  logic [ID_W-1:0]       r_res_id;
  logic [DATA_WIDTH-1:0] r_res_re, r_res_im;

  logic signed [PW-1:0]  w_p_re, w_p_im;
  logic                  w_unused_bits;

  // A held output freezes the whole pipeline.
  assign w_en = !(r_res_valid && !i_res_ready);

`ifdef COMPMUL_ARB_PRIO0_EN
  logic [N_REQ-2:0] w_sub_grant;
  logic [ID_W-1:0]  w_sub_id;

  rr_grant #(.N(N_REQ - 1), .ID_W(ID_W)) u_rr (
    .i_req   (i_req_valid[N_REQ-1:1]),
    .i_ptr   (r_ptr),
    .o_grant (w_sub_grant),
    .o_id    (w_sub_id)
  );

  // Requester 0 overrides; r_ptr indexes requesters 1..N_REQ-1 from zero.
  always_comb begin
    w_grant    = i_req_valid[0] ? N_REQ'(1) : {w_sub_grant, 1'b0};
    w_grant_id = i_req_valid[0] ? '0 : w_sub_id + 1'b1;
  end
`else
  rr_grant #(.N(N_REQ), .ID_W(ID_W)) u_rr (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_id    (w_grant_id)
  );
`endif

  assign o_req_ready = (w_en && !i_rst) ? w_grant : '0;
  assign w_accept    = |(i_req_valid & o_req_ready);

  // Pointer moves just past the requester that was served.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_ptr <= '0;
    end else if (w_accept) begin
`ifdef COMPMUL_ARB_PRIO0_EN
      if (w_grant_id != '0)
        r_ptr <= (w_sub_id == ID_W'(N_REQ - 2)) ? '0 : w_sub_id + 1'b1;
`else
      r_ptr <= (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : w_grant_id + 1'b1;
`endif
    end
  end

  // Stage 1 valid: flush and reset drop whatever is in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr)
      r_s1_valid <= 1'b0;
    else if (w_en)
      r_s1_valid <= w_accept;
  end

  // Stage 1 operands captured only on a real handshake.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_s1_id  <= w_grant_id;
      r_s1_are <= i_a_re[int'(w_grant_id)*DATA_WIDTH +: DATA_WIDTH];
      r_s1_aim <= i_a_im[int'(w_grant_id)*DATA_WIDTH +: DATA_WIDTH];
      r_s1_bre <= i_b_re[int'(w_grant_id)*DATA_WIDTH +: DATA_WIDTH];
      r_s1_bim <= i_b_im[int'(w_grant_id)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  compmul #(.DW(DATA_WIDTH)) u_mul (
    .i_a_re (r_s1_are),
    .i_a_im (r_s1_aim),
    .i_b_re (r_s1_bre),
    .i_b_im (r_s1_bim),
    .o_p_re (w_p_re),
    .o_p_im (w_p_im)
  );

  // Bits outside the result slice are discarded by design.
  assign w_unused_bits = ^{w_p_re[PW-1:HI+1], w_p_re[LO-1:0],
                           w_p_im[PW-1:HI+1], w_p_im[LO-1:0]};

  // Stage 2 valid follows stage 1 whenever the pipeline advances.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr)
      r_res_valid <= 1'b0;
    else if (w_en)
      r_res_valid <= r_s1_valid;
  end

  // Stage 2 data: cleared on reset so outputs read zero, then loaded per op.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_res_id <= '0;
      r_res_re <= '0;
      r_res_im <= '0;
    end else if (w_en && r_s1_valid) begin
      r_res_id <= r_s1_id;
      r_res_re <= w_p_re[HI:LO];
      r_res_im <= w_p_im[HI:LO];
    end
  end

  assign o_res_valid = r_res_valid;
  assign o_res_id    = r_res_id;
  assign o_res_re    = r_res_re;
  assign o_res_im    = r_res_im;

endmodule

// File: tb/tb_compmul_arb.sv
// Self-checking bench for compmul_arb: scoreboard of expected products,
// pushed at each accepted request and popped at each delivered result.
`timescale 1ns/1ps
module tb_compmul_arb;

  localparam int DW  = 16;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst, clr;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*DW-1:0] a_re, a_im, b_re, b_im;
  logic            res_valid, res_ready;
  logic [IDW-1:0]  res_id;
  logic [DW-1:0]   res_re, res_im;

  always #5 clk = ~clk;

  compmul_arb dut (
    .i_clk(clk), .i_rst(rst), .i_clr(clr),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_a_re(a_re), .i_a_im(a_im), .i_b_re(b_re), .i_b_im(b_im),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_id(res_id), .o_res_re(res_re), .o_res_im(res_im)
  );

  typedef struct {
    int          id;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } exp_t;

  exp_t          sb[$];
  int            acc_log[$];
  int            checks = 0;
  int            errors = 0;
  int            n_results = 0;
  logic [DW-1:0] last_re, last_im;

  // Reference: exact products, floor by 2^12, keep 16 bits.
  function automatic logic [DW-1:0] model_re(logic [DW-1:0] ar, ai, br, bi);
    longint p;
    p = longint'($signed(ar)) * longint'($signed(br)) - longint'($signed(ai)) * longint'($signed(bi));
    p = p >>> 12;
    return p[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] model_im(logic [DW-1:0] ar, ai, br, bi);
    longint p;
    p = longint'($signed(ar)) * longint'($signed(bi)) + longint'($signed(ai)) * longint'($signed(br));
    p = p >>> 12;
    return p[DW-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(int k, logic [DW-1:0] ar, ai, br, bi);
    a_re[k*DW +: DW] = ar;
    a_im[k*DW +: DW] = ai;
    b_re[k*DW +: DW] = br;
    b_im[k*DW +: DW] = bi;
  endtask

  // Observes every handshake on the negative edge before it takes effect.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (res_valid && res_ready) begin
        checks++;
        n_results++;
        last_re = res_re;
        last_im = res_im;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL result_unexpected: got id=%0d re=%h im=%h, required no result", res_id, res_re, res_im);
        end else begin
          e = sb.pop_front();
          if ({res_id, res_re, res_im} !== {IDW'(e.id), e.re, e.im}) begin
            errors++;
            $display("FAIL result_data: got id=%0d re=%h im=%h, required id=%0d re=%h im=%h",
                     res_id, res_re, res_im, e.id, e.re, e.im);
          end else
            $display("result id=%0d re=%h im=%h", res_id, res_re, res_im);
        end
      end
      if ($countones(req_ready) > 1) begin
        checks++;
        errors++;
        $display("FAIL ready_onehot: got %b, required one-hot or zero", req_ready);
      end
      if (rst || clr) begin
        sb.delete();
      end else begin
        for (int k = 0; k < N; k++) begin
          if (req_valid[k] && req_ready[k]) begin
            e.id = k;
            e.re = model_re(a_re[k*DW +: DW], a_im[k*DW +: DW], b_re[k*DW +: DW], b_im[k*DW +: DW]);
            e.im = model_im(a_re[k*DW +: DW], a_im[k*DW +: DW], b_re[k*DW +: DW], b_im[k*DW +: DW]);
            sb.push_back(e);
            acc_log.push_back(k);
            $display("accept id=%0d a=%h+j%h b=%h+j%h", k, a_re[k*DW +: DW], a_im[k*DW +: DW],
                     b_re[k*DW +: DW], b_im[k*DW +: DW]);
          end
        end
      end
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      if (sb.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: got %0d results pending, required 0", sb.size());
    end
  endtask

  task automatic issue_one(int k, logic [DW-1:0] ar, ai, br, bi);
    bit got = 1'b0;
    step();
    set_op(k, ar, ai, br, bi);
    req_valid = N'(1) << k;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready[k]) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_timeout: got no ready for req %0d, required ready", k);
    end
    step();
    req_valid = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    repeat (3) step();
    @(negedge clk);
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b, required 0000", req_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", res_valid); end
    checks++; if (res_id !== '0) begin errors++; $display("FAIL reset_id: got %0d, required 0", res_id); end
    checks++; if (res_re !== '0) begin errors++; $display("FAIL reset_re: got %h, required 0000", res_re); end
    checks++; if (res_im !== '0) begin errors++; $display("FAIL reset_im: got %h, required 0000", res_im); end
    step();
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    step();
    set_op(1, 16'h1000, 16'h0000, 16'h0000, 16'h1000);
    req_valid = 4'b0010;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b, required 0010", req_ready); end
    step();
    req_valid = '0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_early: got valid=%b one cycle after accept, required 0", res_valid); end
    @(negedge clk);
    checks++;
    if ({res_valid, res_id, res_re, res_im} !== {1'b1, 2'd1, 16'h0000, 16'h1000}) begin
      errors++;
      $display("FAIL single_result: got v=%b id=%0d re=%h im=%h, required v=1 id=1 re=0000 im=1000",
               res_valid, res_id, res_re, res_im);
    end
    wait_drain();
  endtask

  task automatic test_arith();
    issue_one(2, 16'h0800, 16'h0800, 16'h0800, 16'hF800);
    wait_drain();
    checks++;
    if ({last_re, last_im} !== {16'h0800, 16'h0000}) begin
      errors++;
      $display("FAIL arith_half: got re=%h im=%h, required re=0800 im=0000", last_re, last_im);
    end
    issue_one(3, 16'h8000, 16'h0000, 16'hF000, 16'h0000);
    wait_drain();
    checks++;
    if ({last_re, last_im} !== {16'h8000, 16'h0000}) begin
      errors++;
      $display("FAIL arith_wrap: got re=%h im=%h, required re=8000 im=0000", last_re, last_im);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] g;
    int           n0;
    bit           seq_ok = 1'b1;
    step();
    clr = 1'b1;
    req_valid = '0;
    step();
    clr = 1'b0;
    acc_log.delete();
    n0 = n_results;
    for (int k = 0; k < N; k++) set_op(k, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
    req_valid = '1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      g = req_ready;
      step();
      for (int k = 0; k < N; k++)
        if (g[k]) set_op(k, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
    end
    req_valid = '0;
    checks++;
    if (acc_log.size() != 12) begin
      errors++;
      $display("FAIL rr_throughput: got %0d accepts in 12 cycles, required 12", acc_log.size());
    end
    for (int i = 0; i < acc_log.size(); i++) begin
`ifdef COMPMUL_ARB_PRIO0_EN
      if (acc_log[i] != 0) seq_ok = 1'b0;
`else
      if (acc_log[i] != i % N) seq_ok = 1'b0;
`endif
    end
    checks++;
    if (!seq_ok) begin
      errors++;
      $display("FAIL rr_order: got first grants %0d,%0d,%0d,%0d,%0d, required round-robin from 0",
               acc_log[0], acc_log[1], acc_log[2], acc_log[3], acc_log[4]);
    end
    wait_drain();
    checks++;
    if (n_results - n0 != 12) begin
      errors++;
      $display("FAIL rr_results: got %0d results, required 12", n_results - n0);
    end
`ifdef COMPMUL_ARB_PRIO0_EN
    acc_log.delete();
    step();
    req_valid = 4'b1110;
    repeat (6) step();
    req_valid = '0;
    checks++;
    if (acc_log.size() != 6 || acc_log[0] != 1 || acc_log[1] != 2 || acc_log[2] != 3 || acc_log[3] != 1) begin
      errors++;
      $display("FAIL prio_rr: got %0d accepts starting %0d, required 1,2,3,1,...", acc_log.size(), acc_log[0]);
    end
    wait_drain();
`endif
  endtask

  task automatic test_backpressure();
    logic [IDW+2*DW-1:0] snap;
    bit                  hold_ok = 1'b1;
    step();
    for (int k = 0; k < N; k++) set_op(k, 16'h1000 + DW'(k), 16'h0400, 16'hF800 - DW'(k), 16'h0C00);
    req_valid = '1;
    res_ready = 1'b1;
    step();
    step();
    res_ready = 1'b0;
    @(negedge clk);
    snap = {res_id, res_re, res_im};
    checks++;
    if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b, required 1", res_valid); end
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (req_ready !== '0 || res_valid !== 1'b1 || {res_id, res_re, res_im} !== snap) hold_ok = 1'b0;
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL bp_hold: got ready=%b out=%h, required ready=0000 out=%h", req_ready, {res_id, res_re, res_im}, snap);
    end
    step();
    res_ready = 1'b1;
    step();
    step();
    req_valid = '0;
    wait_drain();
  endtask

  task automatic test_flush();
    bit quiet = 1'b1;
    step();
    clr = 1'b1;
    req_valid = '0;
    step();
    clr = 1'b0;
    set_op(1, 16'h1000, 16'h1000, 16'h1000, 16'h1000);
    set_op(2, 16'h2000, 16'h0000, 16'h2000, 16'h0000);
    req_valid = 4'b0110;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL flush_first: got %b, required 0010", req_ready); end
    step();
    clr = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL flush_ready: got %b, required 0100", req_ready); end
    step();
    clr = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL flush_valid: got result after flush, required none"); end
    step();
    req_valid = '1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL flush_ptr: got %b, required 0001", req_ready); end
    step();
    req_valid = '0;
    wait_drain();
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_arith();
    test_round_robin();
    test_backpressure();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
